// File: rtl/pe_pkg.sv
// Shared definitions for the PE array controller.
//
// Contents:
//   PE_DATA_W       - operand / load_data width of a PE
//   PE_ACC_W        - accumulator width inside each PE
//   pe_ctrl_state_t - controller FSM state encoding
//   drain_count()   - cycles the array needs to flush its last operands
package pe_pkg;

    localparam int PE_DATA_W = 8;
    localparam int PE_ACC_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4,
        ST_DONE  = 3'd5
    } pe_ctrl_state_t;

    // The last operand leaves the RAM after ram_lat cycles, then walks
    // through up to rows+cols PEs. One more cycle covers the multiply stage.
    function automatic int drain_count(input int ram_lat, input int rows, input int cols);
        return ram_lat + rows + cols + 1;
    endfunction

endpackage

// File: rtl/pe_skew_line.sv
// 1-bit delay chain used to skew the row/column valids of the array.
//
// Parameters:
//   DEPTH - number of register stages (>= 1)
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset, clears every stage
//   din  - bit to delay
//   dout - din delayed by DEPTH cycles
module pe_skew_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stages;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stages <= '0;
                end else begin
                    stages <= din;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stages <= '0;
                end else begin
                    stages <= {stages[DEPTH-2:0], din};
                end
            end
        end
    endgenerate

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/pe_array_ctrl.sv
// Job sequencer for a ROWS x COLS systolic MAC array.
//
// A job clears the accumulators, streams k_len operand pairs from the A/B
// read RAMs, waits for the array to drain, then reads the ROWS*COLS results
// out one at a time.
//
// Optional feature macro: PE_ARRAY_CTRL_BIAS_EN
//   defined   - extra 8-bit input 'bias' is sampled with start and loaded
//               into every accumulator during CLEAR
//   undefined - no bias port, accumulators are cleared to 0
//
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   start, k_len, a_base,
//   b_base (, bias)           - job request; operands sampled in IDLE only
//   busy                      - FSM not in IDLE
//   done                      - one-cycle pulse at job end
//   ram_a_rd_en/addr          - A-RAM read port (row operands)
//   ram_b_rd_en/addr          - B-RAM read port (column operands)
//   row_vld, col_vld          - skewed operand valids into the array edges
//   pe_en                     - array enable, CLEAR through DRAIN
//   load_vld, load_data       - accumulator load strobe and value
//   pe_busy                   - OR of the PE activity flags
//   res_row, res_col          - result mux select
//   res_vld, res_rdy          - result handshake
//
// Result handshake: a beat transfers on a cycle where res_vld and res_rdy are
// both high; while res_rdy is low, res_vld and the indices hold.
//
// All FSM outputs are registered and change together with the state.
module pe_array_ctrl
    import pe_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int KW      = 8,
    parameter int AW      = 10,
    parameter int RAM_LAT = 1,
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic [AW-1:0]        a_base,
    input  logic [AW-1:0]        b_base,
`ifdef PE_ARRAY_CTRL_BIAS_EN
    input  logic [PE_DATA_W-1:0] bias,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 ram_a_rd_en,
    output logic [AW-1:0]        ram_a_rd_addr,
    output logic                 ram_b_rd_en,
    output logic [AW-1:0]        ram_b_rd_addr,
    output logic [ROWS-1:0]      row_vld,
    output logic [COLS-1:0]      col_vld,
    output logic                 pe_en,
    output logic                 load_vld,
    output logic [PE_DATA_W-1:0] load_data,
    input  logic                 pe_busy,
    output logic [RW-1:0]        res_row,
    output logic [CW-1:0]        res_col,
    output logic                 res_vld,
    input  logic                 res_rdy
);

    localparam int DRAIN_N = drain_count(RAM_LAT, ROWS, COLS);
    localparam int DW      = $clog2(DRAIN_N + 1);

    pe_ctrl_state_t state;
    logic [KW-1:0]  k_len_q;
    logic [KW-1:0]  k;
    logic [AW-1:0]  a_base_q;
    logic [AW-1:0]  b_base_q;
    logic [DW-1:0]  drain_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            k_len_q       <= '0;
            k             <= '0;
            a_base_q      <= '0;
            b_base_q      <= '0;
            drain_cnt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ram_a_rd_en   <= 1'b0;
            ram_a_rd_addr <= '0;
            ram_b_rd_en   <= 1'b0;
            ram_b_rd_addr <= '0;
            pe_en         <= 1'b0;
            load_vld      <= 1'b0;
            load_data     <= '0;
            res_row       <= '0;
            res_col       <= '0;
            res_vld       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_CLEAR;
                        k_len_q  <= k_len;
                        a_base_q <= a_base;
                        b_base_q <= b_base;
                        busy     <= 1'b1;
                        pe_en    <= 1'b1;
                        load_vld <= 1'b1;
`ifdef PE_ARRAY_CTRL_BIAS_EN
                        load_data <= bias;
`else
                        load_data <= '0;
`endif
                    end
                end

                ST_CLEAR: begin
                    load_vld  <= 1'b0;
                    load_data <= '0;
                    k         <= '0;
                    if (k_len_q != '0) begin
                        state         <= ST_FEED;
                        ram_a_rd_en   <= 1'b1;
                        ram_b_rd_en   <= 1'b1;
                        ram_a_rd_addr <= a_base_q;
                        ram_b_rd_addr <= b_base_q;
                    end else begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DW'(DRAIN_N);
                    end
                end

                ST_FEED: begin
                    // Comparing against k_len-1 keeps k inside KW bits even
                    // for the largest k_len.
                    if (k == k_len_q - KW'(1)) begin
                        state         <= ST_DRAIN;
                        ram_a_rd_en   <= 1'b0;
                        ram_b_rd_en   <= 1'b0;
                        ram_a_rd_addr <= '0;
                        ram_b_rd_addr <= '0;
                        drain_cnt     <= DW'(DRAIN_N);
                    end else begin
                        k             <= k + KW'(1);
                        // Addresses wrap naturally modulo 2^AW.
                        ram_a_rd_addr <= ram_a_rd_addr + AW'(1);
                        ram_b_rd_addr <= ram_b_rd_addr + AW'(1);
                    end
                end

                ST_DRAIN: begin
                    // pe_busy catches PEs still working after the nominal
                    // flush time.
                    if (drain_cnt == '0 && !pe_busy) begin
                        state   <= ST_OUT;
                        pe_en   <= 1'b0;
                        res_vld <= 1'b1;
                        res_row <= '0;
                        res_col <= '0;
                    end else if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end

                ST_OUT: begin
                    if (res_vld && res_rdy) begin
                        if (res_col == CW'(COLS - 1)) begin
                            res_col <= '0;
                            if (res_row == RW'(ROWS - 1)) begin
                                state   <= ST_DONE;
                                res_vld <= 1'b0;
                                res_row <= '0;
                                done    <= 1'b1;
                            end else begin
                                res_row <= res_row + RW'(1);
                            end
                        end else begin
                            res_col <= res_col + CW'(1);
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Row i / column j see their operand RAM_LAT+i / RAM_LAT+j cycles after
    // the read was issued, so lane 0 lines up with the RAM data.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row_skew
            pe_skew_line #(.DEPTH(RAM_LAT + gi)) u_row_skew (
                .clk  (clk),
                .rst  (rst),
                .din  (ram_a_rd_en),
                .dout (row_vld[gi])
            );
        end
        for (gi = 0; gi < COLS; gi++) begin : g_col_skew
            pe_skew_line #(.DEPTH(RAM_LAT + gi)) u_col_skew (
                .clk  (clk),
                .rst  (rst),
                .din  (ram_b_rd_en),
                .dout (col_vld[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl on a 2x2 array with single-cycle RAMs.
module tb_pe_array_ctrl;

    localparam int ROWS    = 2;
    localparam int COLS    = 2;
    localparam int KW      = 8;
    localparam int AW      = 10;
    localparam int RAM_LAT = 1;
    localparam int DRAIN_N = 6;   // RAM_LAT + ROWS + COLS + 1

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [KW-1:0]   k_len;
    logic [AW-1:0]   a_base;
    logic [AW-1:0]   b_base;
    logic [7:0]      bias;
    logic            busy;
    logic            done;
    logic            ram_a_rd_en;
    logic [AW-1:0]   ram_a_rd_addr;
    logic            ram_b_rd_en;
    logic [AW-1:0]   ram_b_rd_addr;
    logic [ROWS-1:0] row_vld;
    logic [COLS-1:0] col_vld;
    logic            pe_en;
    logic            load_vld;
    logic [7:0]      load_data;
    logic            pe_busy;
    logic [0:0]      res_row;
    logic [0:0]      res_col;
    logic            res_vld;
    logic            res_rdy;

    int n_checks = 0;
    int n_pass   = 0;

    pe_array_ctrl #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .KW      (KW),
        .AW      (AW),
        .RAM_LAT (RAM_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .k_len         (k_len),
        .a_base        (a_base),
        .b_base        (b_base),
`ifdef PE_ARRAY_CTRL_BIAS_EN
        .bias          (bias),
`endif
        .busy          (busy),
        .done          (done),
        .ram_a_rd_en   (ram_a_rd_en),
        .ram_a_rd_addr (ram_a_rd_addr),
        .ram_b_rd_en   (ram_b_rd_en),
        .ram_b_rd_addr (ram_b_rd_addr),
        .row_vld       (row_vld),
        .col_vld       (col_vld),
        .pe_en         (pe_en),
        .load_vld      (load_vld),
        .load_data     (load_data),
        .pe_busy       (pe_busy),
        .res_row       (res_row),
        .res_col       (res_col),
        .res_vld       (res_vld),
        .res_rdy       (res_rdy)
    );

    // Clock
    always #5 clk = ~clk;

    // Checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] ctl_vec();
        return {busy, done, pe_en, load_vld, ram_a_rd_en, ram_b_rd_en, res_vld,
                row_vld[1], row_vld[0], col_vld[1], col_vld[0]};
    endfunction

    task automatic start_job(input int k, input logic [AW-1:0] a, input logic [AW-1:0] b);
        k_len  = KW'(k);
        a_base = a;
        b_base = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Called at the first sample after start was accepted (FSM in CLEAR).
    // Walks the job cycle by cycle against a timeline derived from k, the
    // drain count, the extra pe_busy hold and the res_rdy pattern.
    task automatic run_job(input int k, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input int hold, input logic [3:0] pat, input bit poke);
        int          out_c;
        int          idx;
        int          j;
        bit          fin;
        bit          rd, r0, r1, in_out, rdy;
        logic [10:0] e;
        logic [7:0]  exp_load;
        out_c = k + 2 + DRAIN_N + hold;
        idx   = 0;
        j     = 0;
        fin   = 1'b0;
`ifdef PE_ARRAY_CTRL_BIAS_EN
        exp_load = bias;
`else
        exp_load = 8'h00;
`endif
        for (int c = 0; c < 300 && !fin; c++) begin
            rd     = (c >= 1 && c <= k);
            r0     = (c >= 2 && c <= k + 1);
            r1     = (c >= 3 && c <= k + 2);
            in_out = (c >= out_c && idx < 4);
            e = {1'b1, idx == 4, c < out_c, c == 0, rd, rd, in_out, r1, r0, r1, r0};
            check($sformatf("ctl k%0d c%0d", k, c), 32'(ctl_vec()), 32'(e));
            if (c == 0) check("load_data", 32'(load_data), 32'(exp_load));
            if (rd) begin
                check($sformatf("addr_a c%0d", c), 32'(ram_a_rd_addr), 32'(AW'(a + AW'(c - 1))));
                check($sformatf("addr_b c%0d", c), 32'(ram_b_rd_addr), 32'(AW'(b + AW'(c - 1))));
            end
            if (in_out) check($sformatf("res_idx c%0d", c), 32'({res_row, res_col}), 32'(idx));
            if (idx == 4) begin
                tick();
                check("after_done", 32'({busy, done, pe_en, res_vld}), 32'h0);
                fin = 1'b1;
            end else begin
                pe_busy = (hold > 0 && c >= k && c < k + 1 + DRAIN_N + hold);
                rdy     = in_out ? pat[j % 4] : 1'b0;
                if (in_out) j++;
                res_rdy = rdy;
                // Requests while busy must be ignored, including new operands.
                start = poke && (c == 1 || c == out_c);
                if (start) begin
                    k_len  = 8'd9;
                    a_base = 10'h155;
                end
                tick();
                start = 1'b0;
                if (rdy) idx++;
            end
        end
        res_rdy = 1'b0;
        pe_busy = 1'b0;
        if (!fin) check("job_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit saw;
        rst     = 1'b1;
        start   = 1'b0;
        k_len   = '0;
        a_base  = '0;
        b_base  = '0;
        bias    = 8'h5A;
        pe_busy = 1'b0;
        res_rdy = 1'b0;
        tick();
        tick();
        check("reset_ctl", 32'(ctl_vec()), 32'h0);
        check("reset_addr", 32'({ram_a_rd_addr, ram_b_rd_addr}), 32'h0);
        check("reset_misc", 32'({load_data, res_row, res_col}), 32'h0);
        rst = 1'b0;
        tick();
        check("idle_ctl", 32'(ctl_vec()), 32'h0);

        // Basic job, results streamed with res_rdy always high.
        start_job(3, 10'h010, 10'h020);
        run_job(3, 10'h010, 10'h020, 0, 4'b1111, 1'b0);

        // Empty job: no reads, straight to drain.
        start_job(0, 10'h000, 10'h000);
        run_job(0, 10'h000, 10'h000, 0, 4'b1111, 1'b0);

        // Back-pressure on the result port: rdy sequence 1,0,0,1 repeating.
        start_job(2, 10'h100, 10'h200);
        run_job(2, 10'h100, 10'h200, 0, 4'b1001, 1'b0);

        // Stragglers keep the FSM in DRAIN.
        start_job(1, 10'h033, 10'h044);
        run_job(1, 10'h033, 10'h044, 5, 4'b1111, 1'b0);

        // Reset in the middle of FEED (k=1).
        start_job(3, 10'h010, 10'h020);
        tick();
        tick();
        check("pre_rst_feed", 32'({ram_a_rd_en, ram_a_rd_addr}), 32'({1'b1, 10'h011}));
        rst = 1'b1;
        tick();
        check("rst_ctl", 32'(ctl_vec()), 32'h0);
        check("rst_addr", 32'({ram_a_rd_addr, ram_b_rd_addr}), 32'h0);
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            saw = saw | done | busy;
        end
        check("no_done_after_rst", 32'(saw), 32'h0);
        start_job(2, 10'h000, 10'h008);
        run_job(2, 10'h000, 10'h008, 0, 4'b1111, 1'b0);

        // Address wrap, plus start pulses while busy.
        start_job(2, 10'h3FF, 10'h3FE);
        run_job(2, 10'h3FF, 10'h3FE, 0, 4'b1111, 1'b1);
        tick();
        check("final_idle", 32'(ctl_vec()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
- Sequencer for a ROWS x COLS systolic array of 8-bit multiply-accumulate PEs. Each PE has a 16-bit accumulator, a 1-cycle multiply stage and neighbour pass-through registers.
- Per job: clears the accumulators, streams K operand pairs from two read RAMs with per-row/per-column skew, waits for the array to drain, then streams the ROWS*COLS results out under a valid/ready handshake.
- Sits between the job-issuing host logic and the PE array.

Parameters:
- ROWS, 4, array rows; A-side RAM lanes.
- COLS, 4, array columns; B-side RAM lanes.
- KW, 8, width of k_len.
- AW, 10, RAM address width.
- RAM_LAT, 1, RAM read latency in cycles (1 or 2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request pulse; sampled in IDLE only.
- k_len  in  KW  inner dimension K; sampled with start.
- a_base  in  AW  A-RAM start address; sampled with start.
- b_base  in  AW  B-RAM start address; sampled with start.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse at job end.
- ram_a_rd_en  out  1  A-RAM read enable.
- ram_a_rd_addr  out  AW  A-RAM read address.
- ram_b_rd_en  out  1  B-RAM read enable.
- ram_b_rd_addr  out  AW  B-RAM read address.
- row_vld  out  ROWS  skewed valid for each row's in0_vld.
- col_vld  out  COLS  skewed valid for each column's in1_vld.
- pe_en  out  1  array enable.
- load_vld  out  1  accumulator load strobe.
- load_data  out  8  value loaded into the accumulators.
- pe_busy  in  1  OR of all PE pe_doing outputs.
- res_row  out  $clog2(ROWS)  result-mux row select.
- res_col  out  $clog2(COLS)  result-mux column select.
- res_vld  out  1  result valid.
- res_rdy  in  1  result ready.

Behaviour:
- Reset, asynchronous: FSM=IDLE; all outputs 0; counters 0; skew shift registers cleared. Asserting rst mid-job aborts the job: no done pulse, array outputs idle in the next cycle.
- States: IDLE, CLEAR, FEED, DRAIN, OUT, DONE.
- IDLE: start=1 latches k_len, a_base, b_base; go to CLEAR. start in any other state is ignored.
- CLEAR: exactly 1 cycle; pe_en=1, load_vld=1, load_data=0. Go to FEED if k_len!=0, else to DRAIN.
- FEED: k_len cycles; k counts 0..k_len-1.
  - ram_a_rd_en=ram_b_rd_en=1; ram_a_rd_addr=a_base+k, ram_b_rd_addr=b_base+k; addresses wrap modulo 2^AW.
  - On the last beat go to DRAIN.
- Skew: row_vld[i] = ram_a_rd_en delayed by RAM_LAT+i cycles; col_vld[j] = ram_b_rd_en delayed by RAM_LAT+j. Row 0 and column 0 are aligned to RAM data.
- DRAIN: counter loads RAM_LAT+ROWS+COLS+1 on entry and decrements. Exit to OUT when the counter is 0 AND pe_busy=0. The pe_busy term covers stragglers.
- pe_en=1 from CLEAR through DRAIN and 0 in OUT/DONE/IDLE, so accumulators hold their values during readout.
- OUT:
  - res_vld=1 with (res_row,res_col) starting at (0,0).
  - On res_vld&res_rdy: res_col increments; when it wraps from COLS-1 to 0, res_row increments.
  - The beat accepted at (ROWS-1,COLS-1) moves the FSM to DONE.
  - res_rdy=0 holds the indices and res_vld stable.
- DONE: done=1 for 1 cycle, then IDLE. busy is low in IDLE, so start may be accepted in the cycle after DONE.
- Arithmetic:
  - k counter is KW bits.
  - k_len=2^KW-1 is legal; no overflow, since the compare is k==k_len-1.
  - The accumulator width is the array's concern; the controller makes no saturation guarantee.

Optional Feature:
- Macro: PE_ARRAY_CTRL_BIAS_EN.
- When defined, an extra input `bias` (8 bits) is sampled with start, and CLEAR drives load_data=bias, so every accumulator starts at bias.
- When undefined, the port is absent and load_data=0.

Decomposition:
- Shared package pe_pkg holds:
  - the FSM state typedef (pe_ctrl_state_t);
  - the constants PE_DATA_W=8 and PE_ACC_W=16;
  - the helper function for the drain count.
- One natural sub-module, pe_skew_line: a parameterised 1-bit delay chain with reset, DEPTH generic, instanced per row and per column.

Test Plan:
1. ROWS=COLS=2, RAM_LAT=1, start with k_len=3, a_base=0x10, b_base=0x20 -> CLEAR 1 cycle, then A addresses 0x10,0x11,0x12 on consecutive cycles. row_vld[0] is high cycles 1-3 after the first read, row_vld[1] cycles 2-4. Results are read in order (0,0),(0,1),(1,0),(1,1), then a single done pulse.
2. k_len=0 -> CLEAR, DRAIN, OUT; all 4 results are 0 (or bias); no RAM reads issued.
3. During OUT, res_rdy toggles 1,0,0,1 -> indices advance only on handshake cycles; res_vld stays high; exactly 4 beats accepted.
4. pe_busy held high 5 cycles past the drain count -> stays in DRAIN until pe_busy falls; pe_en stays 1.
5. rst asserted mid-FEED at k=1 -> next cycle busy=0, all enables and valids 0, no done pulse. A new start with k_len=2 then completes normally.
6. a_base=2^AW-1, k_len=2 -> addresses 0x3FF then 0x000. start pulses while busy are ignored (no restart, latched k_len unchanged).
